// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO.
// Width functions and the read-mode enum.
package fifo_pkg;

  typedef enum logic {
    STD  = 1'b0,
    FWFT = 1'b1
  } fifo_mode_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write port,
// asynchronous read port. Contents are never reset.
module fifo_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with count, almost flags, error
// pulses and selectable standard / FWFT read mode.
module param_sync_fifo #(
  parameter int DEPTH         = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  parameter int FWFT          = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              w_en,
  input  logic                              r_en,
  input  logic [DATA_WIDTH-1:0]             data_in,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              full,
  output logic                              empty,
  output logic                              almost_full,
  output logic                              almost_empty,
  output logic [fifo_pkg::cnt_w(DEPTH)-1:0] count,
  output logic                              overflow,
  output logic                              underflow
);
  import fifo_pkg::*;

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam fifo_mode_e Mode =
    (FWFT != 0) ? fifo_pkg::FWFT : STD;

  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] AfC    = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AeC    = CW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] LastP  = PW'(DEPTH - 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, unf_q;
  logic          wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rdata;

  // Flags come straight from the count register.
  assign full         = (count_q == DepthC);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AfC);
  assign almost_empty = (count_q <= AeC);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_acc = w_en & ~full;
  assign rd_acc = r_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc)
      wr_ptr_d = (wr_ptr_q == LastP) ? '0
               : wr_ptr_q + PW'(1);
    if (rd_acc)
      rd_ptr_d = (rd_ptr_q == LastP) ? '0
               : rd_ptr_q + PW'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= w_en & full;
      unf_q    <= r_en & empty;
    end
  end

  fifo_mem #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  if (Mode == STD) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
      if (rst)         dout_q <= '0;
      else if (rd_acc) dout_q <= rdata;
    end

    assign data_out = dout_q;
  end else begin : g_fwft
    assign data_out = empty ? '0 : rdata;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench: standard and FWFT instances share one stimulus,
// checked against a table and a queue scoreboard.
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] data_in = '0;

  logic [7:0] s_dout, f_dout;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [3:0] s_cnt, f_cnt;

  always #5 clk = ~clk;

  param_sync_fifo #(
    .DEPTH(8), .DATA_WIDTH(8), .AFULL_THRESH(6),
    .AEMPTY_THRESH(1), .FWFT(0)
  ) u_std (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en),
    .data_in(data_in), .data_out(s_dout),
    .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae),
    .count(s_cnt), .overflow(s_ovf), .underflow(s_unf)
  );

  param_sync_fifo #(
    .DEPTH(8), .DATA_WIDTH(8), .AFULL_THRESH(6),
    .AEMPTY_THRESH(1), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en),
    .data_in(data_in), .data_out(f_dout),
    .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae),
    .count(f_cnt), .overflow(f_ovf), .underflow(f_unf)
  );

  typedef struct {
    bit       w;
    bit       r;
    bit [7:0] d;
    int       cnt;
    bit       fl;
    bit       em;
    bit       af;
    bit       ae;
    bit       ov;
    bit       un;
  } vec_t;

  vec_t     tbl[20];
  bit [7:0] sb[$];
  bit [7:0] last_std;
  int       mcnt;
  int       n_pass;
  int       n_tot;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic cycle(input bit w, input bit r,
                       input bit [7:0] d);
    bit wacc, racc, ovf_e, unf_e;
    wacc  = w && (mcnt < 8);
    racc  = r && (mcnt > 0);
    ovf_e = w && (mcnt == 8);
    unf_e = r && (mcnt == 0);
    if (sb.size() > 0) chk("fwft_head", f_dout, sb[0]);
    w_en = w; r_en = r; data_in = d;
    @(posedge clk); #1;
    w_en = 1'b0; r_en = 1'b0;
    if (racc) last_std = sb.pop_front();
    if (wacc) sb.push_back(d);
    mcnt = mcnt + int'(wacc) - int'(racc);
    chk("s_count", s_cnt, mcnt);
    chk("f_count", f_cnt, mcnt);
    chk("s_dout", s_dout, last_std);
    chk("s_full", s_full, mcnt == 8);
    chk("f_empty", f_empty, mcnt == 0);
    chk("s_ovf", s_ovf, ovf_e);
    chk("f_unf", f_unf, unf_e);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cnt"},  s_cnt, 0);
    chk({tag, "_fcnt"}, f_cnt, 0);
    chk({tag, "_em"},   s_empty, 1);
    chk({tag, "_ae"},   s_ae, 1);
    chk({tag, "_fl"},   s_full, 0);
    chk({tag, "_af"},   s_af, 0);
    chk({tag, "_dout"}, s_dout, 0);
    chk({tag, "_fdout"}, f_dout, 0);
    chk({tag, "_ovf"},  s_ovf | f_ovf, 0);
    chk({tag, "_unf"},  s_unf | f_unf, 0);
  endtask

  initial begin
    //        w  r  d      cnt fl em af ae ov un
    tbl[0]  = '{1, 0, 8'h10, 1, 0, 0, 0, 1, 0, 0};
    tbl[1]  = '{1, 0, 8'h11, 2, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 8'h12, 3, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 8'h13, 4, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 8'h14, 5, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 8'h15, 6, 0, 0, 1, 0, 0, 0};
    tbl[6]  = '{1, 0, 8'h16, 7, 0, 0, 1, 0, 0, 0};
    tbl[7]  = '{1, 0, 8'h17, 8, 1, 0, 1, 0, 0, 0};
    tbl[8]  = '{1, 0, 8'hFF, 8, 1, 0, 1, 0, 1, 0};
    tbl[9]  = '{0, 0, 8'h00, 8, 1, 0, 1, 0, 0, 0};
    tbl[10] = '{0, 1, 8'h00, 7, 0, 0, 1, 0, 0, 0};
    tbl[11] = '{0, 1, 8'h00, 6, 0, 0, 1, 0, 0, 0};
    tbl[12] = '{0, 1, 8'h00, 5, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 1, 8'h00, 4, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{0, 1, 8'h00, 3, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{0, 1, 8'h00, 2, 0, 0, 0, 0, 0, 0};
    tbl[16] = '{0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0};
    tbl[17] = '{0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0};
    tbl[18] = '{0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 1};
    tbl[19] = '{0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0};

    n_pass = 0; n_tot = 0; mcnt = 0; last_std = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset("rst");

    // Fill, overflow, drain, underflow.
    foreach (tbl[i]) begin
      cycle(tbl[i].w, tbl[i].r, tbl[i].d);
      chk($sformatf("t%0d_cnt", i), s_cnt, tbl[i].cnt);
      chk($sformatf("t%0d_fl", i),  s_full, tbl[i].fl);
      chk($sformatf("t%0d_em", i),  s_empty, tbl[i].em);
      chk($sformatf("t%0d_af", i),  s_af, tbl[i].af);
      chk($sformatf("t%0d_ae", i),  s_ae, tbl[i].ae);
      chk($sformatf("t%0d_fae", i), f_ae, tbl[i].ae);
      chk($sformatf("t%0d_ov", i),  s_ovf, tbl[i].ov);
      chk($sformatf("t%0d_fov", i), f_ovf, tbl[i].ov);
      chk($sformatf("t%0d_un", i),  s_unf, tbl[i].un);
    end
    chk("hold_17", s_dout, 8'h17);

    // Simultaneous access at count 4 across pointer wrap.
    for (int i = 0; i < 4; i++) cycle(1, 0, 8'h20 + 8'(i));
    for (int i = 0; i < 12; i++) begin
      cycle(1, 1, 8'h24 + 8'(i));
      chk("wrap_cnt", s_cnt, 4);
    end
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'h00);
    chk("wrap_last", s_dout, 8'h2F);

    // FWFT: head visible before the read.
    cycle(1, 0, 8'hA5);
    chk("fwft_a5", f_dout, 8'hA5);
    chk("std_hold", s_dout, 8'h2F);
    cycle(0, 0, 8'h00);
    chk("fwft_a5_idle", f_dout, 8'hA5);
    cycle(0, 1, 8'h00);
    chk("fwft_pop_em", f_empty, 1);
    chk("std_a5", s_dout, 8'hA5);

    // Reset wins over a concurrent write.
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'h50 + 8'(i));
    chk("pre_rst_cnt", s_cnt, 5);
    rst = 1'b1; w_en = 1'b1; data_in = 8'h77;
    @(posedge clk); #1;
    rst = 1'b0; w_en = 1'b0;
    chk_reset("mid");
    sb.delete(); mcnt = 0; last_std = '0;
    cycle(0, 0, 8'h00);
    chk("post_rst_em", f_empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock FIFO. It succeeds the basic synchronous FIFO and adds programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain and is driven through the team's FIFO interface.

## Interface
- DEPTH, 8: number of entries; any value ≥ 2, not restricted to powers of two.
- DATA_WIDTH, 8: word width in bits.
- AFULL_THRESH, DEPTH-1: almost_full asserts when count ≥ AFULL_THRESH; legal range 1..DEPTH.
- AEMPTY_THRESH, 1: almost_empty asserts when count ≤ AEMPTY_THRESH; legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- w_en  in  1  write request.
- r_en  in  1  read request.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AFULL_THRESH.
- almost_empty  out  1  count ≤ AEMPTY_THRESH.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  one-cycle pulse: write attempted while full.
- underflow  out  1  one-cycle pulse: read attempted while empty.

## Operation
- Write acceptance: a write is accepted when w_en && !full. The word is stored at wr_ptr, and wr_ptr advances.
- Read acceptance: a read is accepted when r_en && !empty. rd_ptr advances.
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
  - When full, only the read is accepted.
  - When empty, only the write is accepted. There is no write-through bypass.
- Pointer wrap: each pointer wraps from DEPTH-1 to 0 by explicit compare, not by modulo 2^n.
- count: increments on a write-only accept, decrements on a read-only accept. It never exceeds DEPTH and never goes below 0.
- Flags: full, empty, almost_full and almost_empty are decoded from the count register only, so they are glitch-free and registered-equivalent.
- FWFT=0:
  - data_out is a register loaded with mem[rd_ptr] on an accepted read.
  - Otherwise data_out holds its value.
- FWFT=1:
  - data_out = mem[rd_ptr] whenever !empty; the head word is visible before r_en.
  - An accepted read pops that word.
  - data_out is don't-care while empty, and is driven 0 in RTL.
- overflow: registered, high for exactly one cycle following an edge where w_en && full. The write is dropped and state is unchanged.
- underflow: registered, high for exactly one cycle following an edge where r_en && empty. data_out is unchanged.
- Reset values: wr_ptr = rd_ptr = count = 0, data_out = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = underflow = 0. Memory contents are not reset.
- Reset mid-operation: rst has priority over w_en and r_en in the same cycle. All stored words are discarded.

## Timing
- Write latency (both modes): a write at edge N updates count, empty and the almost-flags after edge N.
- FWFT=0:
  - The earliest read is at edge N+1.
  - Its data appears on data_out after edge N+1.
- FWFT=1: the head word is visible on data_out after edge N, i.e. in cycle N+1 before any read.
- Read latency: 1 cycle in mode 0, 0 cycles in mode 1.
- Throughput: one write and one read per cycle sustained.
- Error pulses: overflow and underflow lag the offending request by one edge.

## Structure
- Shared package fifo_pkg holds:
  - function cnt_w(depth) returning $clog2(depth+1);
  - localparam-style helper ptr_w(depth) returning $clog2(depth), minimum 1;
  - enum fifo_mode_e { STD = 0, FWFT = 1 } for the FWFT parameter.
- Sub-module fifo_mem: a simple dual-port array with write port (we, waddr, wdata) and asynchronous read port (raddr, rdata). Width and depth are parametrised.
- param_sync_fifo itself holds:
  - the pointers, count and flag decode;
  - the data_out register (mode 0);
  - the overflow/underflow registers.

## Test plan
All scenarios use DEPTH=8, DATA_WIDTH=8, AFULL_THRESH=6, AEMPTY_THRESH=1 unless noted.
- Reset: hold rst 2 cycles. Then count=0, empty=1, almost_empty=1, full=0, data_out=0, no error pulses.
- Fill: write 0x10..0x17 on consecutive cycles.
  - almost_empty drops after the 2nd write.
  - almost_full rises after the 6th write.
  - full rises after the 8th write; count=8.
  - A 9th write of 0xFF pulses overflow once and leaves count=8.
- Drain (FWFT=0): read 8 times. data_out is 0x10..0x17, each one cycle after its read. empty=1 after the last read. A further read pulses underflow once and data_out stays 0x17.
- Wrap and simultaneous access: with count=4, assert w_en and r_en together for 12 cycles.
  - count stays 4 throughout.
  - Pointers wrap.
  - Output order matches input order.
- FWFT=1: write 0xA5 while empty.
  - data_out=0xA5 in the next cycle with r_en low.
  - Reading pops it; empty=1 after that edge.
- Mid-operation reset: with count=5 and w_en=1 in the same cycle as rst=1, all outputs take their reset values after the edge and the write is discarded.
